// File: rtl/seq_detect_1011_ctrl.sv
// ----------------------------------------------------------------------------
// seq_detect_1011_ctrl
//   Board-level front end for the 1011 sequence-detector lab. Two bouncy
//   push-buttons (step, clear) are synchronized and debounced. Each step press
//   samples the synchronized data switch into a Moore FSM that detects the
//   serial pattern 1011, with overlapping matches allowed.
//
// Ports
//   clk          in   1  system clock (50 MHz on the board)
//   reset_n      in   1  asynchronous active-low reset
//   step_btn_n   in   1  raw step push-button, active-low, asynchronous
//   clr_btn_n    in   1  raw clear push-button, active-low, asynchronous
//   data_in      in   1  raw data switch, sampled only on a step event
//   state_code   out  4  FSM state S0..S4 encoded as 0..4
//   match_count  out  4  number of detections modulo 16
//   detect       out  1  high while the FSM is in S4
//   bit_hist     out  4  last four sampled bits, bit 0 newest
// ----------------------------------------------------------------------------
module seq_detect_1011_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_btn_n,
    input  logic       clr_btn_n,
    input  logic       data_in,
    output logic [3:0] state_code,
    output logic [3:0] match_count,
    output logic       detect,
    output logic [3:0] bit_hist
);

    localparam int unsigned CODE_W   = 4;
    localparam int unsigned HIST_W   = 4;
    localparam int unsigned NUM_BTN  = 2;
    localparam int unsigned BTN_STEP = 0;
    localparam int unsigned BTN_CLR  = 1;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers (buttons idle high, data idles low)
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;
    logic               r_data_meta;
    logic               r_data_sync;

    assign w_btn_raw = {clr_btn_n, step_btn_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_meta  <= '1;
            r_btn_sync  <= '1;
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
        end else begin
            r_btn_meta  <= w_btn_raw;
            r_btn_sync  <= r_btn_meta;
            r_data_meta <= data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreeing cycle restarts it.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_btn_db;
    logic [NUM_BTN-1:0] r_btn_db_d;
    logic [CNT_W-1:0]   r_db_cnt [NUM_BTN];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_db   <= '1;
            r_btn_db_d <= '1;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_btn_db_d <= r_btn_db;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (r_btn_sync[i] == r_btn_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_btn_db[i] <= r_btn_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle press pulses on the debounced 1->0 edge; release is ignored.
    logic [NUM_BTN-1:0] w_press_evt;
    logic               w_step_evt;
    logic               w_clr_evt;

    assign w_press_evt = r_btn_db_d & ~r_btn_db;
    assign w_step_evt  = w_press_evt[BTN_STEP];
    assign w_clr_evt   = w_press_evt[BTN_CLR];

    // ------------------------------------------------------------------
    // Detector FSM: state register
    // ------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_nxt;
    state_e              w_step_state;
    logic [CODE_W-1:0]   r_count;
    logic [CODE_W-1:0]   w_count_nxt;
    logic [HIST_W-1:0]   r_hist;
    logic [HIST_W-1:0]   w_hist_nxt;
    logic                r_detect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S0;
            r_count  <= '0;
            r_hist   <= '0;
            r_detect <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_hist   <= w_hist_nxt;
            // Registered alongside the state so it always equals (state == S4).
            r_detect <= (w_state_nxt == S4);
        end
    end

    // ------------------------------------------------------------------
    // Detector FSM: transition function for one sampled bit
    // ------------------------------------------------------------------
    always_comb begin
        w_step_state = S0;
        unique case (r_state)
            S0:      w_step_state = r_data_sync ? S1 : S0;
            S1:      w_step_state = r_data_sync ? S1 : S2;
            S2:      w_step_state = r_data_sync ? S3 : S0;
            S3:      w_step_state = r_data_sync ? S4 : S2;
            S4:      w_step_state = r_data_sync ? S1 : S2;
            default: w_step_state = S0;
        endcase
    end

    // ------------------------------------------------------------------
    // Detector FSM: next state / counters; clear beats a coincident step
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hist_nxt  = r_hist;
        if (w_clr_evt) begin
            w_state_nxt = S0;
            w_count_nxt = '0;
            w_hist_nxt  = '0;
        end else if (w_step_evt) begin
            w_state_nxt = w_step_state;
            w_hist_nxt  = {r_hist[HIST_W-2:0], r_data_sync};
            if (w_step_state == S4) begin
                w_count_nxt = r_count + CODE_W'(1);
            end
        end
    end

    assign state_code  = CODE_W'(r_state);
    assign match_count = r_count;
    assign detect      = r_detect;
    assign bit_hist    = r_hist;

endmodule

// File: tb/tb_seq_detect_1011_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_1011_ctrl
//   Directed bench for seq_detect_1011_ctrl with DEBOUNCE_CYCLES = 4. The
//   stimulus thread pushes hand-computed expected outputs into a queue and
//   raises a sample strobe; a separate monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_seq_detect_1011_ctrl;

    logic       clk;
    logic       reset_n;
    logic       step_btn_n;
    logic       clr_btn_n;
    logic       data_in;
    logic [3:0] state_code;
    logic [3:0] match_count;
    logic       detect;
    logic [3:0] bit_hist;

    seq_detect_1011_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_btn_n  (step_btn_n),
        .clr_btn_n   (clr_btn_n),
        .data_in     (data_in),
        .state_code  (state_code),
        .match_count (match_count),
        .detect      (detect),
        .bit_hist    (bit_hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] cnt;
        logic       det;
        logic [3:0] hist;
        logic       rel;    // also require both debounced buttons released
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  sample_ev;
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic void chk(string nm, logic [3:0] got, logic [3:0] want);
        n_chk++;
        if (got !== want) begin
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end else begin
            n_pass++;
        end
    endfunction

    // Monitor: compares every queued expectation when the strobe fires.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(sample_ev);
            while (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, ".state"}, state_code, e.st);
                chk({nm, ".count"}, match_count, e.cnt);
                chk({nm, ".detect"}, {3'b000, detect}, {3'b000, e.det});
                chk({nm, ".hist"}, bit_hist, e.hist);
                if (e.rel) begin
                    chk({nm, ".db_released"}, {2'b00, dut.r_btn_db}, 4'b0011);
                end
            end
        end
    end

    task automatic expect_out(string nm, logic [3:0] st, logic [3:0] cnt,
                              logic det, logic [3:0] hist, logic rel);
        exp_t e;
        e = '{st: st, cnt: cnt, det: det, hist: hist, rel: rel};
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->sample_ev;
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // A full step: data stable, button low 8 cycles, high 8 cycles.
    task automatic step(logic b);
        data_in = b;
        cycles(1);
        step_btn_n = 1'b0;
        cycles(8);
        step_btn_n = 1'b1;
        cycles(8);
    endtask

    task automatic clear_press();
        clr_btn_n = 1'b0;
        cycles(8);
        clr_btn_n = 1'b1;
        cycles(8);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        step_btn_n = 1'b1;
        clr_btn_n  = 1'b1;
        data_in    = 1'b0;
        cycles(3);
        expect_out("reset_hold", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);
        cycles(1);
        reset_n = 1'b1;
        cycles(3);
        expect_out("reset_rel", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);

        // Basic detect 1,0,1,1
        step(1'b1); expect_out("basic1", 4'd1, 4'd0, 1'b0, 4'b0001, 1'b1);
        step(1'b0); expect_out("basic2", 4'd2, 4'd0, 1'b0, 4'b0010, 1'b1);
        step(1'b1); expect_out("basic3", 4'd3, 4'd0, 1'b0, 4'b0101, 1'b1);
        step(1'b1); expect_out("basic4", 4'd4, 4'd1, 1'b1, 4'b1011, 1'b1);

        // Exact latency: outputs change on the 7th edge after the press edge
        data_in = 1'b0;
        cycles(1);
        step_btn_n = 1'b0;
        cycles(6);
        expect_out("lat_before", 4'd4, 4'd1, 1'b1, 4'b1011, 1'b0);
        cycles(1);
        expect_out("lat_after", 4'd2, 4'd1, 1'b0, 4'b0110, 1'b0);
        cycles(1);
        step_btn_n = 1'b1;
        cycles(8);
        expect_out("lat_hold", 4'd2, 4'd1, 1'b0, 4'b0110, 1'b1);

        clear_press();
        expect_out("clear1", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);

        // Overlap 1,0,1,1,0,1,1
        step(1'b1); expect_out("ovl1", 4'd1, 4'd0, 1'b0, 4'b0001, 1'b1);
        step(1'b0); expect_out("ovl2", 4'd2, 4'd0, 1'b0, 4'b0010, 1'b1);
        step(1'b1); expect_out("ovl3", 4'd3, 4'd0, 1'b0, 4'b0101, 1'b1);
        step(1'b1); expect_out("ovl4", 4'd4, 4'd1, 1'b1, 4'b1011, 1'b1);
        step(1'b0); expect_out("ovl5", 4'd2, 4'd1, 1'b0, 4'b0110, 1'b1);
        step(1'b1); expect_out("ovl6", 4'd3, 4'd1, 1'b0, 4'b1101, 1'b1);
        step(1'b1); expect_out("ovl7", 4'd4, 4'd2, 1'b1, 4'b1011, 1'b1);

        // Bounce: low glitches of 1, 2, 3 cycles separated by 1-cycle highs
        data_in = 1'b0;
        cycles(1);
        step_btn_n = 1'b0; cycles(1); step_btn_n = 1'b1; cycles(1);
        step_btn_n = 1'b0; cycles(2); step_btn_n = 1'b1; cycles(1);
        step_btn_n = 1'b0; cycles(3); step_btn_n = 1'b1; cycles(10);
        expect_out("bounce_none", 4'd4, 4'd2, 1'b1, 4'b1011, 1'b1);
        // 4-cycle stable low, then bouncy release
        step_btn_n = 1'b0; cycles(4);
        step_btn_n = 1'b1; cycles(1); step_btn_n = 1'b0; cycles(1);
        step_btn_n = 1'b1; cycles(2); step_btn_n = 1'b0; cycles(1);
        step_btn_n = 1'b1; cycles(3); step_btn_n = 1'b0; cycles(1);
        step_btn_n = 1'b1; cycles(12);
        expect_out("bounce_one", 4'd2, 4'd2, 1'b0, 4'b0110, 1'b1);

        clear_press();
        expect_out("clear2", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);

        // Wrap: 1011 then 15 x 011 -> 16 detections
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        expect_out("wrap_first", 4'd4, 4'd1, 1'b1, 4'b1011, 1'b1);
        for (int r = 0; r < 15; r++) begin
            step(1'b0); step(1'b1); step(1'b1);
            if (r == 13) expect_out("wrap_15", 4'd4, 4'd15, 1'b1, 4'b1011, 1'b1);
        end
        expect_out("wrap_0", 4'd4, 4'd0, 1'b1, 4'b1011, 1'b1);

        // Clear priority: reach S3 with count 3, then press both together
        for (int r = 0; r < 3; r++) begin
            step(1'b0); step(1'b1); step(1'b1);
        end
        step(1'b0); step(1'b1);
        expect_out("prio_pre", 4'd3, 4'd3, 1'b0, 4'b1101, 1'b1);
        data_in = 1'b1;
        cycles(1);
        step_btn_n = 1'b0;
        clr_btn_n  = 1'b0;
        cycles(8);
        step_btn_n = 1'b1;
        clr_btn_n  = 1'b1;
        cycles(8);
        expect_out("prio_clr", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);
        step(1'b1); expect_out("prio_after", 4'd1, 4'd0, 1'b0, 4'b0001, 1'b1);

        // Mid-run reset at S3 with count 5
        clear_press();
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        for (int r = 0; r < 4; r++) begin
            step(1'b0); step(1'b1); step(1'b1);
        end
        step(1'b0); step(1'b1);
        expect_out("rst_pre", 4'd3, 4'd5, 1'b0, 4'b1101, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("rst_async", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b1);
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        step(1'b1); expect_out("rst_after", 4'd1, 4'd0, 1'b0, 4'b0001, 1'b1);

        cycles(2);
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
            n_chk = n_chk + exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
